mmu_8722: RTL and testbench
===========================

MMU_8722 -- requirements
Module: mmu_8722

Interface
REQ-001 SHALL have parameter VERSION, default 8'h20, value returned on reads of $D50B.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have ports a, input, 16 (CPU address), and rw, input, 1 (1 = read).
REQ-005 SHALL have ports aec, input, 1 (1 = CPU owns bus), and wr_stb, input, 1 (one-cycle write qualifier).
REQ-006 SHALL have ports d_in, input, 8 (write data); d_out, output, 8 (read data); and d_oe, output, 1 (drive data bus).
REQ-007 SHALL have ports game, exrom, k4080, all input, 1; each is a raw pin level read back through MCR.
REQ-008 SHALL have mode outputs ms0, ms1, ms2, ms3, z80en, each 1 bit, consumed by the PLA.
REQ-009 SHALL have outputs fsdir, 1, fast-serial direction; ta, 8, translated address A15..A8; bank, 2, CPU RAM bank; vicbank, 2, VIC RAM bank.

Function
REQ-010 Register map when ms2=0 (I/O visible): $D500 CR, $D501-$D504 PCRA-D, $D505 MCR, $D506 RCR, $D507 P0L, $D508 P0H, $D509 P1L, $D50A P1H, $D50B version (read-only); $D50C-$D5FF not decoded.
REQ-011 Map always visible, independent of ms2: $FF00 CR, $FF01-$FF04 LCRA-D.
REQ-012 Write: takes effect on the clk edge where aec=1, rw=0, wr_stb=1 and the address is decoded; any other cycle leaves all registers unchanged.
REQ-013 A write to $FF01-$FF04 SHALL load CR from PCRA-D respectively, ignoring d_in; PCR contents are unchanged.
REQ-014 Page pointers: a write to PxH SHALL update only a hidden shadow; a write to PxL SHALL commit PxL=d_in and PxH=shadow in the same edge.
REQ-015 A read of PxH SHALL return the committed value, not the shadow.
REQ-016 Read (combinational): d_oe=1 iff aec=1, rw=1 and the address is decoded; d_out=register value; d_out=8'h00 when d_oe=0.
REQ-017 MCR read value SHALL be {k4080, MCR[6], exrom, game, MCR[3], 2'b11, MCR[0]}; only bits 6, 3 and 0 are writable.
REQ-018 Output mapping: ms0=CR[5], ms1=CR[4], ms2=CR[0], ms3=~MCR[6], z80en=MCR[0], fsdir=MCR[3], bank=CR[7:6], vicbank=RCR[7:6].
REQ-019 Translation when aec=1: page a[15:8]==8'h00 maps to ta=P0L; page P0L (when P0L!=0) maps to ta=8'h00; pages 8'h01 and P1L swap likewise; all other pages pass through.
REQ-020 Translation when aec=0: ta=a[15:8].
REQ-021 Translation priority: page 0 swap is checked before page 1; if P0L==P1L, page P1L maps by the P0 rule.
REQ-022 Common RAM: if RCR[2] or RCR[3] is set and the access falls in a common area, bank=2'b00. Bottom area (RCR[2]) is pages below size S; top area (RCR[3]) is pages at or above 256-S. S=RCR[1:0]: 0 gives 4, 1 gives 16, 2 gives 32, 3 gives 64 pages.
REQ-023 Simultaneous events: writing the same register from $D5xx and $FFxx cannot occur (one address per cycle); a write to CR in a cycle changes the outputs from the next cycle.

Reset
REQ-024 While rst_n=0 at a clk edge: CR, PCRA-D, MCR, RCR, P0L, P0H, P1H and the shadows SHALL be 8'h00, and P1L SHALL be 8'h01.
REQ-025 Resulting outputs: ms0..ms3=0,0,0,1; z80en=0; fsdir=0; bank=0; vicbank=0.
REQ-026 Reset SHALL override a coincident write; a pending shadow SHALL be discarded.

Structure
REQ-027 Package mmu_pkg SHALL hold the register offset constants, reset values, the VERSION default and the common-area size table.
REQ-028 Sub-module mmu_page_ptr (shadow-high plus commit-on-low, reset value parameter) SHALL be instantiated twice, for P0 and P1.

Verification
REQ-029 Reset, then read $D50B -> 8'h20; read $D509 -> 8'h01; ms3=1, z80en=0.
REQ-030 Write $D502=8'h3E, then write $FF02 with any data -> CR=8'h3E; ms2=0, ms1=1, ms0=1, bank=0; $D502 still reads 8'h3E.
REQ-031 Write $D508=8'h01 then read $D508 -> 8'h00. Write $D507=8'h40 -> read $D508 gives 8'h01; access $0023 gives ta=8'h40; access $4023 gives ta=8'h00.
REQ-032 Write $FF00=8'h01 (I/O hidden), then write $D505=8'hFF -> MCR unchanged; write $FF00=8'h00, write $D505=8'h41 with game=0, exrom=1, k4080=1 -> read $D505=8'hE7, ms3=0, z80en=1.
REQ-033 RCR=8'h05 and CR=8'h40: access $0200 gives bank=0; access $1000 gives bank=1.
REQ-034 Write $D508=8'h02, then assert rst_n=0 for one cycle, then write $D507=8'h10 -> P0H reads 8'h00.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared constants for the MMU: register offsets, reset values, version and
// the common-RAM size table.
package mmu_pkg;

    localparam logic [7:0] VERSION_DEF = 8'h20;

    localparam logic [7:0] IO_PAGE  = 8'hD5;
    localparam logic [7:0] LCR_PAGE = 8'hFF;

    localparam logic [7:0] OFF_CR   = 8'h00;
    localparam logic [7:0] OFF_PCRA = 8'h01;
    localparam logic [7:0] OFF_PCRB = 8'h02;
    localparam logic [7:0] OFF_PCRC = 8'h03;
    localparam logic [7:0] OFF_PCRD = 8'h04;
    localparam logic [7:0] OFF_MCR  = 8'h05;
    localparam logic [7:0] OFF_RCR  = 8'h06;
    localparam logic [7:0] OFF_P0L  = 8'h07;
    localparam logic [7:0] OFF_P0H  = 8'h08;
    localparam logic [7:0] OFF_P1L  = 8'h09;
    localparam logic [7:0] OFF_P1H  = 8'h0A;
    localparam logic [7:0] OFF_VER  = 8'h0B;
    localparam logic [7:0] OFF_LCRD = 8'h04;

    localparam logic [7:0] RST_REG = 8'h00;
    localparam logic [7:0] RST_P1L = 8'h01;

    // Number of pages in each common-RAM area, selected by RCR[1:0].
    function automatic logic [7:0] common_pages(input logic [1:0] sel);
        case (sel)
            2'd0:    common_pages = 8'd4;
            2'd1:    common_pages = 8'd16;
            2'd2:    common_pages = 8'd32;
            default: common_pages = 8'd64;
        endcase
    endfunction

endpackage

// File: rtl/mmu_page_ptr.sv
// Page pointer: writes to the high byte park in a shadow, and a write to the
// low byte commits low and shadowed high together.
module mmu_page_ptr #(
    parameter logic [7:0] RST_LO = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_wr_lo,
    input  logic       i_wr_hi,
    input  logic [7:0] i_d,
    output logic [7:0] o_lo,
    output logic [7:0] o_hi
);

    logic [7:0] r_lo;
    logic [7:0] r_hi;
    logic [7:0] r_shadow;

    // Shadow capture and low-byte commit.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_lo     <= RST_LO;
            r_hi     <= 8'h00;
            r_shadow <= 8'h00;
        end else begin
            if (i_wr_hi) begin
                r_shadow <= i_d;
            end
            if (i_wr_lo) begin
                r_lo <= i_d;
                r_hi <= r_shadow;
            end
        end
    end

    assign o_lo = r_lo;
    assign o_hi = r_hi;

endmodule

// File: rtl/mmu_8722.sv
// MMU top: configuration register file, read mux, page translation and
// common-RAM bank override.
module mmu_8722
    import mmu_pkg::*;
#(
    parameter logic [7:0] VERSION = VERSION_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic        rw,
    input  logic        aec,
    input  logic        wr_stb,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic        game,
    input  logic        exrom,
    input  logic        k4080,
    output logic        ms0,
    output logic        ms1,
    output logic        ms2,
    output logic        ms3,
    output logic        z80en,
    output logic        fsdir,
    output logic [7:0]  ta,
    output logic [1:0]  bank,
    output logic [1:0]  vicbank
);

    logic [7:0] r_cr;
    logic [7:0] r_rcr;
    logic [7:0] r_pcr [0:3];
    logic [2:0] r_mcr;   // writable MCR bits {6, 3, 0}

    logic [7:0] w_page;
    logic [7:0] w_off;
    logic [1:0] w_pidx;
    logic       w_io_sel;
    logic       w_lcr_sel;
    logic       w_dec;
    logic       w_wr;
    logic [7:0] w_p0l, w_p0h, w_p1l, w_p1h;
    logic [7:0] w_rdata;
    logic [7:0] w_ta;
    logic [7:0] w_size;
    logic       w_common;

    assign w_page    = a[15:8];
    assign w_off     = a[7:0];
    assign w_pidx    = w_off[1:0] - 2'd1;
    assign w_io_sel  = (w_page == IO_PAGE) && (r_cr[0] == 1'b0) && (w_off <= OFF_VER);
    assign w_lcr_sel = (w_page == LCR_PAGE) && (w_off <= OFF_LCRD);
    assign w_dec     = w_io_sel | w_lcr_sel;
    assign w_wr      = aec & ~rw & wr_stb & w_dec;

    mmu_page_ptr #(.RST_LO(RST_REG)) u_p0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_wr_lo (w_wr & w_io_sel & (w_off == OFF_P0L)),
        .i_wr_hi (w_wr & w_io_sel & (w_off == OFF_P0H)),
        .i_d     (d_in),
        .o_lo    (w_p0l),
        .o_hi    (w_p0h)
    );

    mmu_page_ptr #(.RST_LO(RST_P1L)) u_p1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_wr_lo (w_wr & w_io_sel & (w_off == OFF_P1L)),
        .i_wr_hi (w_wr & w_io_sel & (w_off == OFF_P1H)),
        .i_d     (d_in),
        .o_lo    (w_p1l),
        .o_hi    (w_p1h)
    );

    // Configuration register writes; $FF01-$FF04 copy a preset into CR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cr  <= RST_REG;
            r_rcr <= RST_REG;
            r_mcr <= 3'b000;
            for (int i = 0; i < 4; i++) begin
                r_pcr[i] <= RST_REG;
            end
        end else if (w_wr) begin
            if (w_lcr_sel) begin
                if (w_off == OFF_CR) begin
                    r_cr <= d_in;
                end else begin
                    r_cr <= r_pcr[w_pidx];
                end
            end else begin
                case (w_off)
                    OFF_CR:   r_cr <= d_in;
                    OFF_PCRA, OFF_PCRB, OFF_PCRC, OFF_PCRD: r_pcr[w_pidx] <= d_in;
                    OFF_MCR:  r_mcr <= {d_in[6], d_in[3], d_in[0]};
                    OFF_RCR:  r_rcr <= d_in;
                    default:  ;
                endcase
            end
        end
    end

    // Read data mux.
    always_comb begin
        w_rdata = 8'h00;
        if (w_lcr_sel) begin
            if (w_off == OFF_CR) begin
                w_rdata = r_cr;
            end else begin
                w_rdata = r_pcr[w_pidx];
            end
        end else if (w_io_sel) begin
            case (w_off)
                OFF_CR:   w_rdata = r_cr;
                OFF_PCRA, OFF_PCRB, OFF_PCRC, OFF_PCRD: w_rdata = r_pcr[w_pidx];
                OFF_MCR:  w_rdata = {k4080, r_mcr[2], exrom, game, r_mcr[1], 2'b11, r_mcr[0]};
                OFF_RCR:  w_rdata = r_rcr;
                OFF_P0L:  w_rdata = w_p0l;
                OFF_P0H:  w_rdata = w_p0h;
                OFF_P1L:  w_rdata = w_p1l;
                OFF_P1H:  w_rdata = w_p1h;
                OFF_VER:  w_rdata = VERSION;
                default:  w_rdata = 8'h00;
            endcase
        end else begin
            w_rdata = 8'h00;
        end
    end

    assign d_oe  = aec & rw & w_dec;
    assign d_out = d_oe ? w_rdata : 8'h00;

    // Page swap; the P0 pair wins whenever it overlaps the P1 pair.
    always_comb begin
        w_ta = w_page;
        if (!aec) begin
            w_ta = w_page;
        end else if (w_page == 8'h00) begin
            w_ta = w_p0l;
        end else if (w_page == w_p0l) begin
            w_ta = 8'h00;
        end else if (w_page == 8'h01) begin
            w_ta = w_p1l;
        end else if (w_page == w_p1l) begin
            w_ta = 8'h01;
        end else begin
            w_ta = w_page;
        end
    end

    assign ta = w_ta;

    // 8'h00 - size wraps to 256 - size, the first page of the top area.
    assign w_size   = common_pages(r_rcr[1:0]);
    assign w_common = (r_rcr[2] && (w_page < w_size)) ||
                      (r_rcr[3] && (w_page >= (8'h00 - w_size)));

    assign bank    = w_common ? 2'b00 : r_cr[7:6];
    assign vicbank = r_rcr[7:6];
    assign ms0     = r_cr[5];
    assign ms1     = r_cr[4];
    assign ms2     = r_cr[0];
    assign ms3     = ~r_mcr[2];
    assign z80en   = r_mcr[0];
    assign fsdir   = r_mcr[1];

endmodule

// File: tb/tb_mmu_8722.sv
// Bench for mmu_8722: directed scenarios plus random traffic, checked every
// cycle against a register-level behavioural model.
module tb_mmu_8722;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a = 16'h1234;
    logic        rw = 1'b1;
    logic        aec = 1'b1;
    logic        wr_stb = 1'b0;
    logic [7:0]  d_in = 8'h00;
    logic        game = 1'b1, exrom = 1'b1, k4080 = 1'b0;
    logic [7:0]  d_out;
    logic        d_oe, ms0, ms1, ms2, ms3, z80en, fsdir;
    logic [7:0]  ta;
    logic [1:0]  bank, vicbank;

    always #5 clk = ~clk;

    mmu_8722 dut (
        .clk(clk), .rst_n(rst_n), .a(a), .rw(rw), .aec(aec), .wr_stb(wr_stb),
        .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .game(game), .exrom(exrom),
        .k4080(k4080), .ms0(ms0), .ms1(ms1), .ms2(ms2), .ms3(ms3), .z80en(z80en),
        .fsdir(fsdir), .ta(ta), .bank(bank), .vicbank(vicbank)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic [7:0] m_cr, m_mcr, m_rcr, m_p0l, m_p0h, m_p1l, m_p1h, m_s0, m_s1;
    logic [7:0] m_pcr [0:3];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_decoded(input logic [15:0] adr);
        return (adr >= 16'hFF00 && adr <= 16'hFF04) ||
               (m_cr[0] == 1'b0 && adr >= 16'hD500 && adr <= 16'hD50B);
    endfunction

    function automatic logic [7:0] m_read(input logic [15:0] adr);
        case (adr)
            16'hFF00, 16'hD500: return m_cr;
            16'hFF01, 16'hD501: return m_pcr[0];
            16'hFF02, 16'hD502: return m_pcr[1];
            16'hFF03, 16'hD503: return m_pcr[2];
            16'hFF04, 16'hD504: return m_pcr[3];
            16'hD505: return {k4080, m_mcr[6], exrom, game, m_mcr[3], 2'b11, m_mcr[0]};
            16'hD506: return m_rcr;
            16'hD507: return m_p0l;
            16'hD508: return m_p0h;
            16'hD509: return m_p1l;
            16'hD50A: return m_p1h;
            16'hD50B: return 8'h20;
            default:  return 8'h00;
        endcase
    endfunction

    // Translation as a swap table: P1 swaps laid down first, P0 swaps over them.
    function automatic logic [7:0] m_ta(input logic [15:0] adr, input logic ae);
        logic [7:0] map [0:255];
        if (!ae) return adr[15:8];
        for (int i = 0; i < 256; i++) map[i] = 8'(i);
        map[1] = m_p1l;
        map[m_p1l] = 8'h01;
        map[0] = m_p0l;
        map[m_p0l] = 8'h00;
        return map[adr[15:8]];
    endfunction

    function automatic logic [1:0] m_bank(input logic [15:0] adr);
        int pg = int'(adr[15:8]);
        int s;
        case (m_rcr[1:0])
            2'd0:    s = 4;
            2'd1:    s = 16;
            2'd2:    s = 32;
            default: s = 64;
        endcase
        if ((m_rcr[2] && pg < s) || (m_rcr[3] && pg >= 256 - s)) return 2'b00;
        return m_cr[7:6];
    endfunction

    task automatic m_clock();
        if (!rst_n) begin
            m_cr = 8'h00; m_mcr = 8'h00; m_rcr = 8'h00;
            m_p0l = 8'h00; m_p0h = 8'h00; m_p1l = 8'h01; m_p1h = 8'h00;
            m_s0 = 8'h00; m_s1 = 8'h00;
            for (int i = 0; i < 4; i++) m_pcr[i] = 8'h00;
        end else if (aec && !rw && wr_stb && m_decoded(a)) begin
            case (a)
                16'hFF00, 16'hD500: m_cr = d_in;
                16'hFF01, 16'hFF02, 16'hFF03, 16'hFF04: m_cr = m_pcr[int'(a) - 'hFF01];
                16'hD501, 16'hD502, 16'hD503, 16'hD504: m_pcr[int'(a) - 'hD501] = d_in;
                16'hD505: m_mcr = d_in & 8'h49;
                16'hD506: m_rcr = d_in;
                16'hD507: begin m_p0l = d_in; m_p0h = m_s0; end
                16'hD508: m_s0 = d_in;
                16'hD509: begin m_p1l = d_in; m_p1h = m_s1; end
                16'hD50A: m_s1 = d_in;
                default: ;
            endcase
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("d_oe", {15'd0, d_oe}, {15'd0, aec && rw && m_decoded(a)});
            chk("d_out", {8'd0, d_out}, {8'd0, (aec && rw && m_decoded(a)) ? m_read(a) : 8'h00});
            chk("ms", {12'd0, ms0, ms1, ms2, ms3}, {12'd0, m_cr[5], m_cr[4], m_cr[0], ~m_mcr[6]});
            chk("z80en_fsdir", {14'd0, z80en, fsdir}, {14'd0, m_mcr[0], m_mcr[3]});
            chk("ta", {8'd0, ta}, {8'd0, m_ta(a, aec)});
            chk("bank", {14'd0, bank}, {14'd0, m_bank(a)});
            chk("vicbank", {14'd0, vicbank}, {14'd0, m_rcr[7:6]});
        end
    end

    task automatic step();
        @(posedge clk);
        m_clock();
        #1;
    endtask

    task automatic drive(input logic [15:0] adr, input logic r, input logic ae,
                         input logic st, input logic [7:0] dv);
        a = adr; rw = r; aec = ae; wr_stb = st; d_in = dv;
    endtask

    task automatic wr(input logic [15:0] adr, input logic [7:0] dv);
        drive(adr, 1'b0, 1'b1, 1'b1, dv);
        step();
    endtask

    task automatic rd(input logic [15:0] adr, input logic [7:0] exp, input string name);
        drive(adr, 1'b1, 1'b1, 1'b0, 8'h00);
        #2;
        chk(name, {8'd0, d_out}, {8'd0, exp});
        chk({name, "_model"}, {8'd0, m_read(adr)}, {8'd0, exp});
        step();
    endtask

    task automatic access(input logic [15:0] adr);
        drive(adr, 1'b1, 1'b1, 1'b0, 8'h00);
        #2;
    endtask

    initial begin
        step();
        step();
        chk("rst_ms", {12'd0, ms0, ms1, ms2, ms3}, 16'h0001);
        chk("rst_z80_fs_bank", {10'd0, z80en, fsdir, bank, vicbank}, 16'h0000);
        rst_n = 1'b1;
        chk_en = 1'b1;

        rd(16'hD50B, 8'h20, "version");
        rd(16'hD509, 8'h01, "p1l_reset");
        chk("ms3_z80_after_reset", {14'd0, ms3, z80en}, 16'h0002);

        wr(16'hD502, 8'h3E);
        wr(16'hFF02, 8'h99);
        chk("lcr_outputs", {10'd0, ms2, ms1, ms0, 1'b0, bank}, 16'h0018);
        rd(16'hFF00, 8'h3E, "cr_from_pcrb");
        rd(16'hD502, 8'h3E, "pcrb_kept");

        wr(16'hD508, 8'h01);
        rd(16'hD508, 8'h00, "p0h_shadow_hidden");
        wr(16'hD507, 8'h40);
        rd(16'hD508, 8'h01, "p0h_committed");
        access(16'h0023);
        chk("ta_page0", {8'd0, ta}, 16'h0040);
        step();
        access(16'h4023);
        chk("ta_page40", {8'd0, ta}, 16'h0000);
        step();

        wr(16'hFF00, 8'h01);
        wr(16'hD505, 8'hFF);
        wr(16'hFF00, 8'h00);
        game = 1'b0; exrom = 1'b1; k4080 = 1'b1;
        rd(16'hD505, 8'hA6, "mcr_unchanged_hidden");
        wr(16'hD505, 8'h41);
        rd(16'hD505, 8'hE7, "mcr_readback");
        chk("ms3_z80_mcr", {14'd0, ms3, z80en}, 16'h0001);

        wr(16'hD506, 8'h05);
        wr(16'hFF00, 8'h40);
        access(16'h0200);
        chk("bank_common", {14'd0, bank}, 16'h0000);
        step();
        access(16'h1000);
        chk("bank_normal", {14'd0, bank}, 16'h0001);
        step();

        wr(16'hD508, 8'h02);
        rst_n = 1'b0;
        drive(16'h1234, 1'b1, 1'b1, 1'b0, 8'h00);
        step();
        rst_n = 1'b1;
        wr(16'hD507, 8'h10);
        rd(16'hD508, 8'h00, "shadow_discarded");

        for (int i = 0; i < 3000; i++) begin
            logic [15:0] adr;
            logic [7:0]  pg;
            case ($urandom_range(0, 3))
                0: adr = 16'hD500 + 16'($urandom_range(0, 15));
                1: adr = 16'hFF00 + 16'($urandom_range(0, 5));
                2: adr = 16'($urandom);
                default: begin
                    case ($urandom_range(0, 3))
                        0: pg = m_p0l;
                        1: pg = m_p1l;
                        2: pg = 8'h00;
                        default: pg = 8'h01;
                    endcase
                    adr = {pg, 8'($urandom)};
                end
            endcase
            rst_n = ($urandom_range(0, 199) != 0);
            game = 1'($urandom); exrom = 1'($urandom); k4080 = 1'($urandom);
            drive(adr, 1'($urandom), ($urandom_range(0, 7) != 0), 1'($urandom), 8'($urandom));
            step();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
